// File: rtl/pulse_stretch_if.sv
// Event-strobe in, LED blink drive and queue status out; PEND_W must match the attached pulse_stretch.
interface pulse_stretch_if #(
    parameter int PEND_W = 4
);
    logic              pulse_in;
    logic              led_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output pulse_in,
        input  led_out,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  pulse_in,
        output led_out,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/pulse_stretch.sv
// Stretches one-cycle event strobes into fixed-length LED blinks separated by a guaranteed off gap.
// Blink starts one edge after the strobe; excess events queue in a saturating counter, drops set a sticky overflow.
module pulse_stretch #(
    parameter int ON_COUNTS  = 6250000,
    parameter int OFF_COUNTS = 6250000,
    parameter int PEND_W     = 4
) (
    input  logic           clk,
    input  logic           rst,
    pulse_stretch_if.slave bus
);
    localparam int MAXC = (ON_COUNTS > OFF_COUNTS) ? ON_COUNTS : OFF_COUNTS;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_COUNTS - 1);
    localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_COUNTS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              led_q, led_d;
    logic              busy_q, busy_d;
    logic              avail;
    logic              start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
        end
    end

    // A strobe in the same cycle as a start launches the blink directly and never enters the queue.
    always_comb begin
        avail   = (pend_q != '0) || bus.pulse_in;
        start   = avail && ((state_q == S_IDLE) ||
                            ((state_q == S_GAP) && (timer_q == '0)));
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ON;
                    timer_d = ON_LOAD;
                end
            end
            S_ON: begin
                if (timer_q == '0) begin
                    state_d = S_GAP;
                    timer_d = OFF_LOAD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_GAP: begin
                if (timer_q == '0) begin
                    state_d = start ? S_ON : S_IDLE;
                    timer_d = start ? ON_LOAD : '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

        if (bus.pulse_in && !start) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1);
            end
        end else if (!bus.pulse_in && start) begin
            pend_d = pend_q - PEND_W'(1);
        end
    end

    always_comb begin
        led_d  = (state_d == S_ON);
        busy_d = (state_d != S_IDLE);
    end

    assign bus.led_out  = led_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pend_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_pulse_stretch.sv
module tb_pulse_stretch;
    localparam int ON  = 4;
    localparam int OFF = 3;
    localparam int PW  = 2;
    localparam int PMAX = (1 << PW) - 1;

    typedef struct {
        int k;
        bit led;
        bit busy;
        int pend;
        bit ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb[$];

    // reference model: blink timing derived from the start edge of the last blink
    int m_k;
    int m_ls;
    int m_pend;
    bit m_ovf;

    pulse_stretch_if #(.PEND_W(PW)) bus ();

    pulse_stretch #(
        .ON_COUNTS (ON),
        .OFF_COUNTS(OFF),
        .PEND_W    (PW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_ls   = m_k - 1000;
        m_pend = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic check(input string name, input int k, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", name, k, got, want);
        end
    endtask

    // One clock: drive inputs on the falling edge, predict what the next rising edge produces.
    task automatic cyc(input bit p, input bit r);
        exp_t e;
        bit   avail;
        bit   st;
        int   k;
        @(negedge clk);
        rst = r;
        bus.pulse_in = p;
        k = m_k;
        m_k++;
        if (!r) begin
            model_reset();
            e = '{k: k, led: 1'b0, busy: 1'b0, pend: 0, ovf: 1'b0};
        end else begin
            avail = (m_pend > 0) || p;
            st = avail && (k >= m_ls + ON + OFF);
            if (st) m_ls = k;
            if (p && !st) begin
                if (m_pend == PMAX) m_ovf = 1'b1;
                else m_pend++;
            end else if (!p && st) begin
                m_pend--;
            end
            e.k    = k;
            e.led  = (k - m_ls) < ON;
            e.busy = (k - m_ls) < (ON + OFF);
            e.pend = m_pend;
            e.ovf  = m_ovf;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
    endtask

    task automatic async_reset_check();
        @(posedge clk);
        #3;
        rst = 1'b0;
        bus.pulse_in = 1'b0;
        #1;
        check("async_led", m_k, int'(bus.led_out), 0);
        check("async_busy", m_k, int'(bus.busy), 0);
        check("async_pend", m_k, int'(bus.pending), 0);
        check("async_ovf", m_k, int'(bus.overflow), 0);
        model_reset();
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("led_out", e.k, int'(bus.led_out), int'(e.led));
            check("busy", e.k, int'(bus.busy), int'(e.busy));
            check("pending", e.k, int'(bus.pending), e.pend);
            check("overflow", e.k, int'(bus.overflow), int'(e.ovf));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog edge=%0d got=timeout want=finish", m_k);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        failures = 0;
        m_k = 0;
        rst = 1'b0;
        bus.pulse_in = 1'b0;
        model_reset();
        #2;
        check("reset_led", 0, int'(bus.led_out), 0);
        check("reset_busy", 0, int'(bus.busy), 0);
        check("reset_pend", 0, int'(bus.pending), 0);
        check("reset_ovf", 0, int'(bus.overflow), 0);

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
        idle(3);

        // single pulse from idle
        cyc(1'b1, 1'b1);
        idle(12);

        // three back-to-back pulses
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        idle(30);

        // five back-to-back pulses: one dropped
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
        idle(35);

        // second pulse lands in the final gap cycle
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        idle(6);
        cyc(1'b1, 1'b1);
        idle(14);

        // asynchronous reset mid-blink with events queued
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
        async_reset_check();
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0);
        idle(2);
        cyc(1'b1, 1'b1);
        idle(12);

        // six-cycle held strobe
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1);
        idle(35);

        // randomized traffic at varying densities, with occasional resets
        for (int ph = 0; ph < 8; ph++) begin
            int dens;
            dens = (ph % 4 == 0) ? 3 : (ph % 4 == 1) ? 12 : (ph % 4 == 2) ? 35 : 70;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 299) == 0) cyc(1'($urandom_range(0, 1)), 1'b0);
                else cyc(1'($urandom_range(0, 99) < dens), 1'b1);
            end
            idle(40);
        end

        @(posedge clk);
        #3;
        check("scoreboard_drained", m_k, sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
